// File: rtl/spi_ram_master_pkg.sv
// Shared opcodes, frame widths and FSM encoding for the SPI RAM master.
// Optional SPI_RAM_MASTER_SEQ_CHECK_EN adds read-sequence checking in the top.
package spi_ram_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_SHIFT,
        ST_WAIT,
        ST_RECV,
        ST_GAP
    } state_e;

endpackage

// File: rtl/spi_ram_master_if.sv
// Command/response bundle between a requester and the SPI RAM master.
// Unaffected by SPI_RAM_MASTER_SEQ_CHECK_EN (seq_err is a plain top port).
interface spi_ram_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;

    modport master (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/spi_ram_master_shifter.sv
// MSB-first frame shift-out, byte shift-in and shared phase counter.
// Same in both SPI_RAM_MASTER_SEQ_CHECK_EN builds.
module spi_ram_master_shifter
    import spi_ram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [FRAME_BITS-1:0] word_i,
    input  logic                  shift_i,
    input  logic                  sample_i,
    input  logic                  miso_i,
    input  logic                  cnt_clr_i,
    input  logic                  cnt_inc_i,
    output logic                  tx_bit_o,
    output logic [DATA_BITS-1:0]  rx_o,
    output logic [3:0]            cnt_o
);

    logic [FRAME_BITS-1:0] tx_q;
    logic [DATA_BITS-1:0]  rx_q;
    logic [3:0]            cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q  <= '0;
            rx_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (load_i) begin
                tx_q <= word_i;
            end else if (shift_i) begin
                tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
            end
            if (sample_i) begin
                rx_q <= rx_o;
            end
            if (cnt_clr_i) begin
                cnt_q <= '0;
            end else if (cnt_inc_i) begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    // rx_o includes the bit being sampled this cycle so the
    // final byte can be taken on the 8th sample edge.
    assign rx_o     = {rx_q[DATA_BITS-2:0], miso_i};
    assign tx_bit_o = tx_q[FRAME_BITS-1];
    assign cnt_o    = cnt_q;

endmodule

// File: rtl/spi_ram_master.sv
// SPI master for the single-port-RAM slave: one bit per clk, read replies on rsp.
// Define SPI_RAM_MASTER_SEQ_CHECK_EN to drop rd_data not preceded by rd_addr.
module spi_ram_master
    import spi_ram_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int GAP    = 1
) (
    input  logic clk,
    input  logic rst,
    spi_ram_master_if.master bus,
    output logic SS_n,
    output logic MOSI,
    input  logic MISO
`ifdef SPI_RAM_MASTER_SEQ_CHECK_EN
    ,
    output logic seq_err
`endif
);

    state_e               state_q;
    logic                 ss_n_q;
    logic                 mosi_q;
    logic                 ready_q;
    logic                 rsp_valid_q;
    logic [DATA_BITS-1:0] rsp_data_q;
    logic                 busy_q;
    logic                 rd_q;

    logic                 accept;
    logic                 drop;
    logic                 last;
    logic                 shift;
    logic                 sample;
    logic                 cnt_clr;
    logic                 cnt_inc;
    logic                 tx_bit;
    logic [DATA_BITS-1:0] rx_word;
    logic [3:0]           cnt;

    assign accept  = bus.cmd_valid && bus.cmd_ready;
    assign shift   = (state_q == ST_CMD) || (state_q == ST_SHIFT);
    assign sample  = (state_q == ST_RECV);
    assign cnt_clr = last || (state_q == ST_IDLE) || (state_q == ST_CMD);
    assign cnt_inc = !cnt_clr;

    always_comb begin
        last = 1'b0;
        case (state_q)
            ST_SHIFT: last = (cnt == 4'(FRAME_BITS - 1));
            ST_WAIT:  last = (cnt == 4'(RD_LAT - 1));
            ST_RECV:  last = (cnt == 4'(DATA_BITS - 1));
            ST_GAP:   last = (cnt == 4'(GAP - 1));
            default:  last = 1'b0;
        endcase
    end

    spi_ram_master_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept),
        .word_i    ({bus.cmd_op, bus.cmd_data}),
        .shift_i   (shift),
        .sample_i  (sample),
        .miso_i    (MISO),
        .cnt_clr_i (cnt_clr),
        .cnt_inc_i (cnt_inc),
        .tx_bit_o  (tx_bit),
        .rx_o      (rx_word),
        .cnt_o     (cnt)
    );

`ifdef SPI_RAM_MASTER_SEQ_CHECK_EN
    logic armed_q;
    logic seq_err_q;

    assign drop = accept && (bus.cmd_op == OP_RD_DATA) && !armed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q   <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= drop;
            if (accept && bus.cmd_op == OP_RD_ADDR) begin
                armed_q <= 1'b1;
            end else if (accept && bus.cmd_op == OP_RD_DATA) begin
                armed_q <= 1'b0;
            end
        end
    end

    assign seq_err = seq_err_q;
`else
    assign drop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            rd_q        <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (!drop) begin
                            state_q <= ST_CMD;
                            ss_n_q  <= 1'b0;
                            mosi_q  <= bus.cmd_op[1];
                            busy_q  <= 1'b1;
                            rd_q    <= (bus.cmd_op == OP_RD_DATA);
                        end
                    end
                end
                ST_CMD: begin
                    state_q <= ST_SHIFT;
                    mosi_q  <= tx_bit;
                end
                ST_SHIFT: begin
                    if (last) begin
                        mosi_q <= 1'b0;
                        if (rd_q) begin
                            state_q <= ST_WAIT;
                        end else begin
                            state_q <= ST_GAP;
                            ss_n_q  <= 1'b1;
                        end
                    end else begin
                        mosi_q <= tx_bit;
                    end
                end
                ST_WAIT: begin
                    if (last) begin
                        state_q <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (last) begin
                        state_q     <= ST_GAP;
                        ss_n_q      <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= rx_word;
                    end
                end
                ST_GAP: begin
                    if (last) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Reset forces ready low in the same cycle it is asserted.
    assign bus.cmd_ready = ready_q && !rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = busy_q;
    assign SS_n          = ss_n_q;
    assign MOSI          = mosi_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed + random bench for spi_ram_master with a RAM-slave model.
// Handles both SPI_RAM_MASTER_SEQ_CHECK_EN builds.
module tb_spi_ram_master;
    import spi_ram_pkg::*;

    localparam int RD_LAT = 2;
    localparam int GAP    = 1;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic MISO = 1'b0;
    logic SS_n;
    logic MOSI;
`ifdef SPI_RAM_MASTER_SEQ_CHECK_EN
    logic seq_err;
`endif

    spi_ram_master_if bus ();

    spi_ram_master #(
        .RD_LAT (RD_LAT),
        .GAP    (GAP)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .SS_n (SS_n),
        .MOSI (MOSI),
        .MISO (MISO)
`ifdef SPI_RAM_MASTER_SEQ_CHECK_EN
        ,
        .seq_err (seq_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [10:0] bits;
        int          hi;
        bit          tail_bad;
    } frame_t;

    frame_t frames[$];
    int checks    = 0;
    int failures  = 0;
    int rv_cycles = 0;
    int se_cycles = 0;

    // Slave-side view of the wire
    int          lowcnt = 0;
    int          hicnt  = 0;
    int          hi_at  = 0;
    logic [10:0] sh     = '0;
    bit          tail_bad = 0;
    logic [7:0]  sl_mem[256];
    logic [7:0]  sl_addr = '0;
    logic [7:0]  reply   = '0;
    bit          sl_rd   = 0;

    // Reference model of the RAM contents as seen by the requester
    logic [7:0]  ref_mem[256];
    logic [7:0]  ref_addr  = '0;
    bit          ref_armed = 0;
    logic [7:0]  last_rsp  = '0;

    function automatic void slave_decode();
        case (sh[9:8])
            2'b00, 2'b10: sl_addr = sh[7:0];
            2'b01:        sl_mem[sl_addr] = sh[7:0];
            default: begin
                reply = sl_mem[sl_addr];
                sl_rd = 1;
            end
        endcase
    endfunction

    always @(negedge clk) begin : mon
        int idx;
        if (rst) begin
            lowcnt   = 0;
            hicnt    = 0;
            tail_bad = 0;
            MISO     = 1'b0;
        end else begin
            if (bus.rsp_valid === 1'b1) rv_cycles++;
`ifdef SPI_RAM_MASTER_SEQ_CHECK_EN
            if (seq_err === 1'b1) se_cycles++;
`endif
            if (SS_n === 1'b0) begin
                if (lowcnt == 0) begin
                    hi_at = hicnt;
                    hicnt = 0;
                    sl_rd = 0;
                end
                if (lowcnt < 11) sh = {sh[9:0], MOSI};
                else if (MOSI !== 1'b0) tail_bad = 1;
                if (lowcnt == 10) slave_decode();
                idx  = lowcnt - 11 - RD_LAT;
                MISO = (sl_rd && idx >= 0 && idx < 8) ? reply[7 - idx] : 1'b0;
                lowcnt++;
            end else begin
                if (lowcnt > 0) frames.push_back('{lowcnt, sh, hi_at, tail_bad});
                lowcnt   = 0;
                tail_bad = 0;
                MISO     = 1'b0;
                hicnt++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] d,
                         input bit hold);
        int n = 0;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 200), 1);
        @(posedge clk);
        #1;
        bus.cmd_op   = 2'($urandom);
        bus.cmd_data = 8'($urandom);
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 200), 1);
        @(negedge clk);
    endtask

    task automatic exp_frame(input logic [1:0] op, input logic [7:0] d,
                             output frame_t f);
        f = '{0, '0, 0, 0};
        chk("frame_present", 32'(frames.size() > 0), 1);
        if (frames.size() == 0) return;
        f = frames.pop_front();
        chk("frame_len", f.len, (op == OP_RD_DATA) ? 11 + RD_LAT + 8 : 11);
        chk("frame_bits", 32'(f.bits), 32'({op[1], op, d}));
        chk("frame_tail_mosi", 32'(f.tail_bad), 0);
        case (op)
            OP_WR_ADDR, OP_RD_ADDR: ref_addr = d;
            OP_WR_DATA:             ref_mem[ref_addr] = d;
            default:                last_rsp = ref_mem[ref_addr];
        endcase
    endtask

    task automatic run(input logic [1:0] op, input logic [7:0] d);
        int     rv0 = rv_cycles;
        int     se0 = se_cycles;
        bit     drop = 0;
        frame_t f;
`ifdef SPI_RAM_MASTER_SEQ_CHECK_EN
        drop = (op == OP_RD_DATA) && !ref_armed;
`endif
        issue(op, d, 0);
        wait_idle();
        if (drop) begin
            chk("drop_no_frame", frames.size(), 0);
            chk("seq_err_pulse", se_cycles - se0, 1);
            chk("drop_no_rsp", rv_cycles - rv0, 0);
        end else begin
            exp_frame(op, d, f);
            chk("rsp_pulses", rv_cycles - rv0, 32'(op == OP_RD_DATA));
            chk("no_seq_err", se_cycles - se0, 0);
        end
        chk("rsp_data", 32'(bus.rsp_data), 32'(last_rsp));
        if (op == OP_RD_ADDR) ref_armed = 1;
        else if (op == OP_RD_DATA) ref_armed = 0;
    endtask

    initial begin : stim
        int         rv0;
        frame_t     f;
        logic [1:0] bops[4];
        logic [7:0] bdat[4];
        logic [7:0] a;

        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'(i) ^ 8'h5A;
            sl_mem[i]  = 8'(i) ^ 8'h5A;
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_data  = '0;
        rst           = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ssn", 32'(SS_n), 1);
        chk("rst_mosi", 32'(MOSI), 0);
        chk("rst_ready", 32'(bus.cmd_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ready_after_rst", 32'(bus.cmd_ready), 1);

        // Abort a wr_addr frame in the middle of its shift phase
        rv0 = rv_cycles;
        issue(OP_WR_ADDR, 8'hA5, 0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_ready_low", 32'(bus.cmd_ready), 0);
            if (k == 0) begin
                chk("abort_ssn", 32'(SS_n), 1);
                chk("abort_busy", 32'(bus.busy), 0);
                chk("abort_mosi", 32'(MOSI), 0);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_back", 32'(bus.cmd_ready), 1);
        chk("abort_no_rsp", rv_cycles - rv0, 0);
        chk("abort_no_frame", frames.size(), 0);
        chk("abort_rsp_data", 32'(bus.rsp_data), 0);

        // rd_data straight after reset
        run(OP_RD_DATA, 8'($urandom));

        run(OP_WR_ADDR, 8'hA5);
        run(OP_WR_DATA, 8'h3C);
        run(OP_RD_ADDR, 8'hA5);
        run(OP_RD_DATA, 8'($urandom));

        // Back-to-back with cmd_valid held high
        bops = '{OP_RD_ADDR, OP_RD_DATA, OP_WR_ADDR, OP_WR_DATA};
        for (int k = 0; k < 4; k++) bdat[k] = 8'($urandom);
        rv0 = rv_cycles;
        for (int k = 0; k < 4; k++) issue(bops[k], bdat[k], k < 3);
        wait_idle();
        chk("b2b_frames", frames.size(), 4);
        for (int k = 0; k < 4; k++) begin
            exp_frame(bops[k], bdat[k], f);
            if (k > 0) chk("b2b_gap", f.hi, GAP + 1);
        end
        ref_armed = 0;
        chk("b2b_rsp_pulses", rv_cycles - rv0, 1);
        chk("b2b_rsp_data", 32'(bus.rsp_data), 32'(last_rsp));

        // Response holds across a later write
        a = 8'($urandom);
        run(OP_WR_ADDR, a);
        run(OP_WR_DATA, 8'hFF);
        run(OP_RD_ADDR, a);
        run(OP_RD_DATA, 8'h00);
        chk("hold_ff", 32'(bus.rsp_data), 32'h0000_00FF);
        run(OP_WR_DATA, 8'h00);
        chk("hold_after_wr", 32'(bus.rsp_data), 32'h0000_00FF);

        for (int k = 0; k < 16; k++) begin
            run(2'($urandom_range(0, 3)), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
